// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive with programmable dead time; absorbs and counts short pulses.
// Outputs are registered from the next state (one-edge latency); no backpressure, one decision per clock.
module pwm_deadtime #(
   parameter int DT_BITS  = 8,
   parameter int CNT_BITS = 16
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                en_in,
   input  logic                pwm_in,
   input  logic [DT_BITS-1:0]  dt_in,
   input  logic                clr_in,
   output logic                pwm_hi_out,
   output logic                pwm_lo_out,
   output logic                dead_out,
   output logic [CNT_BITS-1:0] glitch_cnt_out
);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_DT_HI,
      ST_HI,
      ST_DT_LO,
      ST_LO
   } state_t;

   state_t               state, state_nxt;
   logic [DT_BITS-1:0]   dt_cnt, dt_cnt_nxt, dt_load;
   logic                 glitch;

   // Counter holds remaining dead cycles minus one; a setting of 0 behaves as 1.
   assign dt_load = (dt_in == '0) ? '0 : dt_in - DT_BITS'(1);

   always_comb begin
      state_nxt  = state;
      dt_cnt_nxt = dt_cnt;
      glitch     = 1'b0;
      if (!en_in) begin
         state_nxt = ST_OFF;
      end else begin
         case (state)
            ST_OFF: begin
               state_nxt  = pwm_in ? ST_DT_HI : ST_DT_LO;
               dt_cnt_nxt = dt_load;
            end
            ST_HI: begin
               if (!pwm_in) begin
                  state_nxt  = ST_DT_LO;
                  dt_cnt_nxt = dt_load;
               end
            end
            ST_LO: begin
               if (pwm_in) begin
                  state_nxt  = ST_DT_HI;
                  dt_cnt_nxt = dt_load;
               end
            end
            ST_DT_HI: begin
               // Returning to the side that was just released needs no dead time.
               if (!pwm_in) begin
                  state_nxt = ST_LO;
                  glitch    = 1'b1;
               end else if (dt_cnt == '0) begin
                  state_nxt = ST_HI;
               end else begin
                  dt_cnt_nxt = dt_cnt - DT_BITS'(1);
               end
            end
            ST_DT_LO: begin
               if (pwm_in) begin
                  state_nxt = ST_HI;
                  glitch    = 1'b1;
               end else if (dt_cnt == '0) begin
                  state_nxt = ST_LO;
               end else begin
                  dt_cnt_nxt = dt_cnt - DT_BITS'(1);
               end
            end
            default: state_nxt = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= ST_OFF;
         dt_cnt         <= '0;
         pwm_hi_out     <= 1'b0;
         pwm_lo_out     <= 1'b0;
         dead_out       <= 1'b0;
         glitch_cnt_out <= '0;
      end else begin
         state      <= state_nxt;
         dt_cnt     <= dt_cnt_nxt;
         pwm_hi_out <= (state_nxt == ST_HI);
         pwm_lo_out <= (state_nxt == ST_LO);
         dead_out   <= (state_nxt == ST_DT_HI) || (state_nxt == ST_DT_LO);
         if (clr_in) begin
            glitch_cnt_out <= '0;
         end else if (glitch && (glitch_cnt_out != '1)) begin
            glitch_cnt_out <= glitch_cnt_out + CNT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime with a queue-based scoreboard and an abstract reference model.
module tb_pwm_deadtime;

   localparam int DTB = 8;
   localparam int CNB = 4;
   localparam int CNT_MAX = (1 << CNB) - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           en = 1'b0;
   logic           pwm = 1'b0;
   logic [DTB-1:0] dt = '0;
   logic           clr = 1'b0;
   logic           hi, lo, dead;
   logic [CNB-1:0] gcnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       hi;
      logic       lo;
      logic       dead;
      logic [3:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: which side is driven, which side a dead gap is heading to, cycles of gap left.
   int side  = 0;   // 0 none, 1 high, 2 low
   int head  = 0;
   bit in_gap = 1'b0;
   int remain = 0;
   int m_cnt = 0;

   pwm_deadtime #(.DT_BITS(DTB), .CNT_BITS(CNB)) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .en_in         (en),
      .pwm_in        (pwm),
      .dt_in         (dt),
      .clr_in        (clr),
      .pwm_hi_out    (hi),
      .pwm_lo_out    (lo),
      .dead_out      (dead),
      .glitch_cnt_out(gcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_edge(input bit e, input bit p, input int d_set, input bit c);
      int want = p ? 1 : 2;
      int d = (d_set == 0) ? 1 : d_set;
      bit g = 1'b0;
      if (!e) begin
         side   = 0;
         in_gap = 1'b0;
      end else if (in_gap) begin
         remain = remain - 1;
         if (want != head) begin
            in_gap = 1'b0;
            side   = want;
            g      = 1'b1;
         end else if (remain == 0) begin
            in_gap = 1'b0;
            side   = head;
         end
      end else if (side != want) begin
         in_gap = 1'b1;
         head   = want;
         remain = d;
         side   = 0;
      end
      if (c) m_cnt = 0;
      else if (g && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
   endfunction

   function automatic void model_reset();
      side   = 0;
      in_gap = 1'b0;
      remain = 0;
      m_cnt  = 0;
   endfunction

   task automatic step(input bit e, input bit p, input int d, input bit c);
      exp_t x;
      @(negedge clk);
      en  = e;
      pwm = p;
      dt  = d[DTB-1:0];
      clr = c;
      model_edge(e, p, d, c);
      x.hi   = !in_gap && side == 1;
      x.lo   = !in_gap && side == 2;
      x.dead = in_gap;
      x.cnt  = m_cnt[3:0];
      exp_q.push_back(x);
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst) chk("overlap", {31'd0, hi & lo}, 32'd0);
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("hi", {31'd0, hi}, {31'd0, mon_e.hi});
         chk("lo", {31'd0, lo}, {31'd0, mon_e.lo});
         chk("dead", {31'd0, dead}, {31'd0, mon_e.dead});
         chk("glitch_cnt", {28'd0, gcnt}, {28'd0, mon_e.cnt});
      end
   end

   initial begin
      int run;
      bit p;
      #1 rst = 1'b1;
      #1;
      chk("rst_hi", {31'd0, hi}, 32'd0);
      chk("rst_lo", {31'd0, lo}, 32'd0);
      chk("rst_dead", {31'd0, dead}, 32'd0);
      chk("rst_cnt", {28'd0, gcnt}, 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Drive into HI, then hit async reset mid-HI.
      repeat (6) step(1, 1, 2, 0);
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      #1;
      chk("async_rst_hi", {31'd0, hi}, 32'd0);
      chk("async_rst_lo", {31'd0, lo}, 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Enable from OFF heading low with dt=4.
      repeat (8) step(1, 0, 4, 0);

      // Square wave 20/20, dt=5.
      for (int k = 0; k < 3; k++) begin
         repeat (20) step(1, 1, 5, 0);
         repeat (20) step(1, 0, 5, 0);
      end

      // dt=0 acts as one dead cycle.
      for (int k = 0; k < 4; k++) begin
         repeat (6) step(1, 1, 0, 0);
         repeat (6) step(1, 0, 0, 0);
      end

      // Short pulse in LO with dt=6.
      repeat (10) step(1, 0, 6, 0);
      step(1, 0, 6, 1);
      repeat (3) step(1, 1, 6, 0);
      repeat (10) step(1, 0, 6, 0);

      // Saturation then clear coincident with a glitch.
      for (int k = 0; k < 20; k++) begin
         repeat (2) step(1, 1, 6, 0);
         repeat (3) step(1, 0, 6, 0);
      end
      repeat (2) step(1, 1, 6, 0);
      step(1, 0, 6, 1);
      repeat (3) step(1, 0, 6, 0);

      // Disable during dead time, then re-enable heading high with dt=3.
      repeat (10) step(1, 0, 5, 0);
      repeat (2) step(1, 1, 5, 0);
      repeat (3) step(0, 1, 5, 0);
      repeat (6) step(1, 1, 3, 0);

      // Random traffic: pwm runs, dt changing freely, sparse disable and clear.
      p = 1'b0;
      run = 0;
      for (int k = 0; k < 3000; k++) begin
         if (run == 0) begin
            p = ~p;
            run = $urandom_range(12, 1);
         end
         run--;
         step(($urandom_range(99, 0) >= 3), p, $urandom_range(7, 0),
              ($urandom_range(99, 0) < 2));
      end

      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #2;
      chk("drain", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
